button_conditioner: RTL and testbench



---
 rtl/ducks_input_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 53 +++++
 rtl/button_conditioner.sv | 172 +++++++++++++++++
 tb/tb_button_conditioner.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ducks_input_pkg.sv
// Shared definitions for the player input front end: fire FSM states,
// timing constants for the 25 MHz pixel clock and shortened ones for simulation.
package ducks_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        COOLDOWN     = 2'd1,
        WAIT_RELEASE = 2'd2,
        EMPTY        = 2'd3
    } fire_state_t;

    // 10 ms debounce and 250 ms shot cooldown at 25 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_COOLDOWN_CYCLES = 6250000;
    localparam int DEFAULT_AMMO_MAX        = 3;

    // Short timings so a simulation can walk through every state quickly
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_COOLDOWN_CYCLES = 8;

    // Width of a counter that must reach cycles-1, never narrower than one bit
    function automatic int counterWidth(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser followed by a counter that only
// lets the stable level flip after the synced input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles.
module debounce_channel
    import ducks_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CW = counterWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/button_conditioner.sv
// Player button front end: debounces left/right/fire, resolves left/right
// conflicts, and turns fire presses into single shot strobes limited by a
// cooldown and a per-round ammo count.
module button_conditioner
    import ducks_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES,
    parameter int AMMO_MAX        = DEFAULT_AMMO_MAX
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           btn_izq_raw,
    input  logic                           btn_der_raw,
    input  logic                           btn_fire_raw,
    input  logic                           reload,
    output logic                           izq,
    output logic                           der,
    output logic                           fire_pulse,
    output logic                           dry_fire,
    output logic [$clog2(AMMO_MAX+1)-1:0]  ammo,
    output logic                           empty
);

    localparam int AW = $clog2(AMMO_MAX + 1);
    localparam int CW = counterWidth(COOLDOWN_CYCLES);
    localparam logic [AW-1:0] AMMO_FULL = AW'(AMMO_MAX);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);

    logic          w_stableIzq;
    logic          w_stableDer;
    logic          w_stableFire;
    logic          w_rise;
    logic          w_coolDone;
    logic          w_shot;
    logic          w_dry;
    logic [AW-1:0] w_ammoNext;
    fire_state_t   r_state;
    fire_state_t   w_stateNext;

    logic          r_firePrev;
    logic [CW-1:0] r_coolCnt;
    logic [AW-1:0] r_ammo;
    logic          r_empty;
    logic          r_firePulse;
    logic          r_dryFire;
    logic          r_izq;
    logic          r_der;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debIzq (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (btn_izq_raw),
        .o_stable (w_stableIzq)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debDer (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (btn_der_raw),
        .o_stable (w_stableDer)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debFire (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (btn_fire_raw),
        .o_stable (w_stableFire)
    );

    assign w_rise     = w_stableFire & ~r_firePrev;
    assign w_coolDone = (r_coolCnt == COOL_LAST);

    // Fire FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Fire FSM next state, shot/dry decisions and next ammo; reload beats a coincident press
    always_comb begin
        w_stateNext = r_state;
        w_shot      = 1'b0;
        w_dry       = 1'b0;
        w_ammoNext  = reload ? AMMO_FULL : r_ammo;
        case (r_state)
            IDLE: begin
                if (w_rise && !reload) begin
                    if (r_ammo != '0) begin
                        w_shot      = 1'b1;
                        w_ammoNext  = r_ammo - AW'(1);
                        w_stateNext = COOLDOWN;
                    end else begin
                        w_dry       = 1'b1;
                        w_stateNext = EMPTY;
                    end
                end
            end
            COOLDOWN: begin
                if (w_coolDone) begin
                    if (w_stableFire) begin
                        w_stateNext = WAIT_RELEASE;
                    end else if (w_ammoNext == '0) begin
                        w_stateNext = EMPTY;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!w_stableFire) begin
                    w_stateNext = (w_ammoNext == '0) ? EMPTY : IDLE;
                end
            end
            EMPTY: begin
                if (reload) begin
                    w_stateNext = w_stableFire ? WAIT_RELEASE : IDLE;
                end else if (w_rise) begin
                    w_dry = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Edge history, cooldown timer, ammo and the registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_firePrev  <= 1'b0;
            r_coolCnt   <= '0;
            r_ammo      <= AMMO_FULL;
            r_empty     <= 1'b0;
            r_firePulse <= 1'b0;
            r_dryFire   <= 1'b0;
        end else begin
            r_firePrev  <= w_stableFire;
            r_ammo      <= w_ammoNext;
            r_empty     <= (w_ammoNext == '0);
            r_firePulse <= w_shot;
            r_dryFire   <= w_dry;
            if (w_shot) begin
                r_coolCnt <= '0;
            end else if (r_state == COOLDOWN) begin
                r_coolCnt <= r_coolCnt + CW'(1);
            end
        end
    end

    // Direction outputs, suppressed when both directions are held
    always_ff @(posedge clk) begin
        if (reset) begin
            r_izq <= 1'b0;
            r_der <= 1'b0;
        end else begin
            r_izq <= w_stableIzq & ~w_stableDer;
            r_der <= w_stableDer & ~w_stableIzq;
        end
    end

    assign izq        = r_izq;
    assign der        = r_der;
    assign fire_pulse = r_firePulse;
    assign dry_fire   = r_dryFire;
    assign ammo       = r_ammo;
    assign empty      = r_empty;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner at simulation timings. A reference model built
// from raw-input history windows and shot timestamps predicts every output on
// every cycle; directed segments add event-count checks.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int C = 8;
    localparam int M = 3;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_COOL  = 1;
    localparam int MODE_HOLD  = 2;
    localparam int MODE_EMPTY = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnIzq;
    logic       btnDer;
    logic       btnFire;
    logic       reloadIn;
    logic       izq;
    logic       der;
    logic       firePulse;
    logic       dryFire;
    logic [1:0] ammo;
    logic       empty;

    int checks     = 0;
    int errors     = 0;
    int cycle      = 0;
    int pulseCount = 0;
    int dryCount   = 0;

    bit [D+1:0] mHist [3];
    bit         mStable [3];
    bit         mLastFire;
    bit         mIzq, mDer, mPulse, mDry, mEmpty;
    logic [1:0] mAmmo;
    int         mMode;
    int         mShotCycle;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .COOLDOWN_CYCLES (C),
        .AMMO_MAX        (M)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_izq_raw  (btnIzq),
        .btn_der_raw  (btnDer),
        .btn_fire_raw (btnFire),
        .reload       (reloadIn),
        .izq          (izq),
        .der          (der),
        .fire_pulse   (firePulse),
        .dry_fire     (dryFire),
        .ammo         (ammo),
        .empty        (empty)
    );

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelStep();
        bit raw [3];
        bit stF;
        bit rise;
        logic [1:0] ammoAfter;
        raw[0] = btnIzq;
        raw[1] = btnDer;
        raw[2] = btnFire;
        if (reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                mHist[ch]   = '0;
                mStable[ch] = 1'b0;
            end
            mLastFire = 1'b0;
            mIzq      = 1'b0;
            mDer      = 1'b0;
            mPulse    = 1'b0;
            mDry      = 1'b0;
            mAmmo     = 2'(M);
            mEmpty    = 1'b0;
            mMode     = MODE_IDLE;
        end else begin
            mIzq      = mStable[0] & ~mStable[1];
            mDer      = mStable[1] & ~mStable[0];
            stF       = mStable[2];
            rise      = stF & ~mLastFire;
            mLastFire = stF;
            mPulse    = 1'b0;
            mDry      = 1'b0;
            ammoAfter = reloadIn ? 2'(M) : mAmmo;
            case (mMode)
                MODE_IDLE: begin
                    if (rise && !reloadIn) begin
                        if (mAmmo > 0) begin
                            mPulse     = 1'b1;
                            ammoAfter  = mAmmo - 2'd1;
                            mMode      = MODE_COOL;
                            mShotCycle = cycle;
                        end else begin
                            mDry  = 1'b1;
                            mMode = MODE_EMPTY;
                        end
                    end
                end
                MODE_COOL: begin
                    if (cycle - mShotCycle == C) begin
                        if (stF) mMode = MODE_HOLD;
                        else     mMode = (ammoAfter == 0) ? MODE_EMPTY : MODE_IDLE;
                    end
                end
                MODE_HOLD: begin
                    if (!stF) mMode = (ammoAfter == 0) ? MODE_EMPTY : MODE_IDLE;
                end
                default: begin
                    if (reloadIn) mMode = stF ? MODE_HOLD : MODE_IDLE;
                    else if (rise) mDry = 1'b1;
                end
            endcase
            mAmmo  = ammoAfter;
            mEmpty = (mAmmo == 0);
            for (int ch = 0; ch < 3; ch++) begin
                mHist[ch] = {mHist[ch][D:0], raw[ch]};
                if (mHist[ch][D+1:2] == {D{~mStable[ch]}}) begin
                    mStable[ch] = ~mStable[ch];
                end
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic checkOutput();
        checkValue("izq",        {31'b0, izq},       {31'b0, mIzq});
        checkValue("der",        {31'b0, der},       {31'b0, mDer});
        checkValue("fire_pulse", {31'b0, firePulse}, {31'b0, mPulse});
        checkValue("dry_fire",   {31'b0, dryFire},   {31'b0, mDry});
        checkValue("ammo",       {30'b0, ammo},      {30'b0, mAmmo});
        checkValue("empty",      {31'b0, empty},     {31'b0, mEmpty});
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            cycle++;
            modelStep();
            #1;
            checkOutput();
            if (firePulse === 1'b1) pulseCount++;
            if (dryFire === 1'b1) dryCount++;
        end
    endtask

    task automatic clearCounts();
        pulseCount = 0;
        dryCount   = 0;
    endtask

    task automatic pressFire(input int highCycles, input int lowCycles);
        btnFire = 1'b1;
        applyStimulus(highCycles);
        btnFire = 1'b0;
        applyStimulus(lowCycles);
    endtask

    task automatic pulseReload();
        reloadIn = 1'b1;
        applyStimulus(1);
        reloadIn = 1'b0;
        applyStimulus(2);
    endtask

    initial begin
        reset    = 1'b1;
        btnIzq   = 1'b0;
        btnDer   = 1'b0;
        btnFire  = 1'b0;
        reloadIn = 1'b0;
        applyStimulus(3);
        reset = 1'b0;
        applyStimulus(2);

        // Left button bouncing, then settling high; then released
        for (int i = 0; i < 20; i++) begin
            btnIzq = ((i / 2) % 2 == 0);
            applyStimulus(1);
        end
        btnIzq = 1'b1;
        applyStimulus(12);
        btnIzq = 1'b0;
        applyStimulus(10);

        // Both directions held, then right released, then left released
        btnIzq = 1'b1;
        btnDer = 1'b1;
        applyStimulus(12);
        btnDer = 1'b0;
        applyStimulus(10);
        btnIzq = 1'b0;
        applyStimulus(10);

        // Single long press gives one shot
        clearCounts();
        pressFire(30, 12);
        checkValue("single_shot_pulses", pulseCount, 1);
        checkValue("single_shot_ammo", {30'b0, ammo}, 2);

        // Second press whose edge lands in the last cooldown cycle is ignored
        clearCounts();
        pressFire(4, 4);
        pressFire(8, 14);
        checkValue("cooldown_pulses", pulseCount, 1);
        checkValue("cooldown_ammo", {30'b0, ammo}, 1);

        // Held button never repeats; a fresh press afterwards fires
        pulseReload();
        clearCounts();
        pressFire(100, 12);
        checkValue("hold_pulses", pulseCount, 1);
        pressFire(8, 12);
        checkValue("hold_next_pulses", pulseCount, 2);
        checkValue("hold_ammo", {30'b0, ammo}, 1);

        // Run dry, then reload and fire again
        pulseReload();
        clearCounts();
        for (int i = 0; i < 4; i++) pressFire(8, 12);
        checkValue("empty_pulses", pulseCount, 3);
        checkValue("empty_dry", dryCount, 1);
        checkValue("empty_ammo", {30'b0, ammo}, 0);
        checkValue("empty_flag", {31'b0, empty}, 1);
        pulseReload();
        checkValue("reload_ammo", {30'b0, ammo}, 3);
        checkValue("reload_empty", {31'b0, empty}, 0);
        clearCounts();
        pressFire(8, 12);
        checkValue("after_reload_pulses", pulseCount, 1);

        // Reload in the very cycle the fire edge is detected
        clearCounts();
        btnFire = 1'b1;
        applyStimulus(D + 2);
        reloadIn = 1'b1;
        applyStimulus(1);
        reloadIn = 1'b0;
        applyStimulus(10);
        btnFire = 1'b0;
        applyStimulus(12);
        checkValue("collision_pulses", pulseCount, 0);
        checkValue("collision_dry", dryCount, 0);
        checkValue("collision_ammo", {30'b0, ammo}, 3);

        // Reset in the middle of a cooldown
        btnFire = 1'b1;
        applyStimulus(D + 3);
        applyStimulus(2);
        clearCounts();
        reset   = 1'b1;
        btnFire = 1'b0;
        applyStimulus(2);
        reset = 1'b0;
        applyStimulus(20);
        checkValue("reset_pulses", pulseCount, 0);
        checkValue("reset_ammo", {30'b0, ammo}, 3);
        checkValue("reset_empty", {31'b0, empty}, 0);

        // Random traffic on every input, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) btnIzq  = ~btnIzq;
            if ($urandom_range(0, 5) == 0) btnDer  = ~btnDer;
            if ($urandom_range(0, 4) == 0) btnFire = ~btnFire;
            reloadIn = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 249) == 0);
            applyStimulus(1);
        end
        reset    = 1'b0;
        reloadIn = 1'b0;
        applyStimulus(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
